ifid_skid_reg: RTL and testbench

- Valid/ready pipeline register between the fetch stage and the decode stage of the pipelined CPU.
- Carries the fetched PC and instruction word into decode.
- A one-entry skid buffer lets in_ready be a registered signal, so a decode stall never forms a combinational path back to fetch.
- Supports a synchronous flush for branch/jump redirect.

---
 rtl/ifid_skid_reg.sv | 133 +++++++++++++
 tb/tb_ifid_skid_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg.sv
// Fetch-to-decode valid/ready pipeline register with a one-entry skid buffer and synchronous flush.
// Optional stall counter output enabled by defining IFID_STALL_CNT_EN.
module ifid_skid_reg #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr
`ifdef IFID_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // Encoding is {s_valid, m_valid}; 2'b10 cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t              state_reg, state_next;
    logic                in_ready_reg;
    logic [DATA_W-1:0]   m_pc_reg, m_instr_reg;
    logic [DATA_W-1:0]   s_pc_reg, s_instr_reg;

    logic in_fire, out_fire, m_valid;
    logic load_main_in, load_main_skid, load_skid;

    assign m_valid  = state_reg[0];
    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = m_valid & out_ready;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush drops the valid bits only; payload registers keep their contents.
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc_reg    <= '0;
            m_instr_reg <= '0;
            s_pc_reg    <= '0;
            s_instr_reg <= '0;
        end else begin
            if (load_main_in) begin
                m_pc_reg    <= in_pc;
                m_instr_reg <= in_instr;
            end else if (load_main_skid) begin
                m_pc_reg    <= s_pc_reg;
                m_instr_reg <= s_instr_reg;
            end
            if (load_skid) begin
                s_pc_reg    <= in_pc;
                s_instr_reg <= in_instr;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = m_valid;
    assign out_pc    = m_pc_reg;
    assign out_instr = m_valid ? m_instr_reg : NOP_WORD;

`ifdef IFID_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Counts fetch back-pressure cycles; only reset clears it, never flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (in_valid && !in_ready_reg) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Randomized and directed bench for ifid_skid_reg against a queue-based reference model.
// Exercises the stall counter as well when IFID_STALL_CNT_EN is defined.
module tb_ifid_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef IFID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: in-flight entries oldest first, as {pc, instr}; capacity two.
    logic [63:0] q[$];
    int unsigned stall_m = 0;

    always #5 clk = ~clk;

    ifid_skid_reg #(.DATA_W(32), .NOP_WORD(NOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
`ifdef IFID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Drives one cycle of stimulus and advances the model; returns 1 time unit after the edge.
    task automatic apply(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        bit inf, outf;
        @(negedge clk);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        inf  = iv && (q.size() < 2);
        outf = ordy && (q.size() > 0);
        if (iv && q.size() == 2) stall_m++;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back({pc, ins});
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== NOP) begin
            miscompares++;
            $display("FAIL reset: ready=%b valid=%b pc=%h instr=%h, required 1 0 0 %h",
                     in_ready, out_valid, out_pc, out_instr, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        stall_m = 0;
    endtask

    task automatic test_first_transfer();
        apply(1'b1, 32'h0000_3000, 32'h2008_0005, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instr !== 32'h2008_0005 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL first_xfer: valid=%b pc=%h instr=%h ready=%b, required 1 00003000 20080005 1",
                     out_valid, out_pc, out_instr, in_ready);
        end
        apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++;
        if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drain: valid=%b instr=%h ready=%b, required 0 %h 1", out_valid, out_instr, in_ready, NOP);
        end
    endtask

    task automatic test_skid_order();
        logic [31:0] exp_pc[6];
        logic        exp_rdy[6];
        logic        exp_vld[6];
        exp_pc  = '{32'h3000, 32'h3000, 32'h3000, 32'h3004, 32'h3008, 32'h3008};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: apply(1'b1, 32'h3000, 32'h3000 ^ 32'hA5A5_0000, 1'b0, 1'b0);
                1: apply(1'b1, 32'h3004, 32'h3004 ^ 32'hA5A5_0000, 1'b0, 1'b0);
                2: apply(1'b1, 32'h3008, 32'h3008 ^ 32'hA5A5_0000, 1'b0, 1'b0);
                3: apply(1'b1, 32'h3008, 32'h3008 ^ 32'hA5A5_0000, 1'b1, 1'b0);
                4: apply(1'b1, 32'h3008, 32'h3008 ^ 32'hA5A5_0000, 1'b1, 1'b0);
                default: apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            endcase
            vectors++;
            if (out_valid !== exp_vld[i] || in_ready !== exp_rdy[i] ||
                (exp_vld[i] && (out_pc !== exp_pc[i] || out_instr !== (exp_pc[i] ^ 32'hA5A5_0000)))) begin
                miscompares++;
                $display("FAIL skid_order step %0d: valid=%b ready=%b pc=%h instr=%h, required %b %b %h %h",
                         i, out_valid, in_ready, out_pc, out_instr, exp_vld[i], exp_rdy[i],
                         exp_pc[i], exp_pc[i] ^ 32'hA5A5_0000);
            end
        end
    endtask

    task automatic test_flush();
        apply(1'b1, 32'h3000, 32'h1111_1111, 1'b0, 1'b0);
        apply(1'b1, 32'h3004, 32'h2222_2222, 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_fill: ready=%b valid=%b, required 0 1", in_ready, out_valid);
        end
        apply(1'b1, 32'h300C, 32'h3333_3333, 1'b0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0 || out_instr !== NOP || in_ready !== 1'b1 || out_pc !== 32'h3000) begin
            miscompares++;
            $display("FAIL flush: valid=%b instr=%h ready=%b pc=%h, required 0 %h 1 00003000",
                     out_valid, out_instr, in_ready, out_pc, NOP);
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            vectors++;
            if (out_valid !== 1'b0 || out_instr !== NOP) begin
                miscompares++;
                $display("FAIL flush_after %0d: valid=%b pc=%h instr=%h, required 0 - %h",
                         i, out_valid, out_pc, out_instr, NOP);
            end
        end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 32'h4000, 32'h4444_0000, 1'b0, 1'b0);
        apply(1'b1, 32'h4004, 32'h4444_0004, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0 || out_instr !== NOP) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b ready=%b pc=%h instr=%h, required 0 1 0 %h",
                     out_valid, in_ready, out_pc, out_instr, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        stall_m = 0;
    endtask

`ifdef IFID_STALL_CNT_EN
    task automatic test_stall_cnt();
        apply(1'b1, 32'h5000, 32'h5555_0000, 1'b0, 1'b0);
        apply(1'b1, 32'h5004, 32'h5555_0004, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) apply(1'b1, 32'h5008, 32'h5555_0008, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt !== 32'd7) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d, required 7", stall_cnt);
        end
        apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (stall_cnt !== 32'd7 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_cnt_flush: got %0d valid=%b, required 7 0", stall_cnt, out_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic        exp_valid, exp_ready;
        logic [31:0] exp_pc, exp_instr;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            apply($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 63) == 0);
            exp_valid = (q.size() > 0);
            exp_ready = (q.size() < 2);
            exp_pc    = exp_valid ? q[0][63:32] : 32'h0;
            exp_instr = exp_valid ? q[0][31:0] : NOP;
            vectors++;
            if (out_valid !== exp_valid || in_ready !== exp_ready || out_instr !== exp_instr ||
                (exp_valid && out_pc !== exp_pc)) begin
                miscompares++;
                $display("FAIL random cyc %0d: valid=%b/%b ready=%b/%b pc=%h/%h instr=%h/%h (got/required)",
                         cyc, out_valid, exp_valid, in_ready, exp_ready, out_pc, exp_pc, out_instr, exp_instr);
            end
        end
`ifdef IFID_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== stall_m) begin
            miscompares++;
            $display("FAIL random_stall_cnt: got %0d, required %0d", stall_cnt, stall_m);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_transfer();
        test_skid_order();
        test_flush();
        test_async_reset();
`ifdef IFID_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
